pid_mc: RTL
===========

Name: pid_mc

Overview:
- Multi-channel, time-multiplexed fixed-point PID controller with a single shared multiplier.
- Same control law as the single-channel PID: proportional term, clamped integrator, first-order filtered derivative.
- Adds runtime-programmable per-channel gains and limits, output saturation with anti-windup, and valid/ready handshakes.
- Sits between per-loop error generators and actuator drivers; serves up to CH independent loops.

Parameters:
- W, 32, total data/coefficient width (signed two's complement).
- FW, 16, fractional bits of all data and coefficients (Q(W-FW).FW).
- CH, 4, number of independent channels (>=1).
- CHW, max(1,$clog2(CH)), channel index width (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  block idle, sample accepted when in_valid&&in_ready
- in_ch  in  CHW  channel of sample
- in_data  in  W  error sample x
- cfg_we  in  1  config write strobe
- cfg_ready  out  1  config write accepted when cfg_we&&cfg_ready
- cfg_ch  in  CHW  config channel
- cfg_sel  in  3  0 P, 1 I*Ts, 2 D/Ts, 3 N*Ts, 4 ILIM, 5 DLIM, 6 OLIM, 7 clear channel state
- cfg_data  in  W  coefficient value (ignored for sel 7)
- out_valid  out  1  one-cycle result pulse, no backpressure
- out_ch  out  CHW  channel of result
- out_data  out  W  controller output
- out_sat  out  1  out_data was clamped to +-OLIM

Behaviour:
- Reset: in_ready=1, cfg_ready=1, out_valid=0, out_ch=0, out_data=0, out_sat=0, FSM=IDLE. All per-channel coefficients, limits, iacc, dacc and sat_dir are cleared to 0.
- Multiply: mul(a,b) = (a*b) computed at 2W bits, arithmetic shift right by FW (floor), saturated to W bits.
- Add/subtract: every add/subtract is done at W+2 bits and saturated to W bits.
- FSM, one state per cycle: IDLE -> S_P -> S_I -> S_D -> S_N -> S_UPD -> S_OUT -> IDLE.
- IDLE: on accept, latch ch and x, and snapshot that channel's 7 config words.
- S_P: xp=mul(x,P).
- S_I: xi=mul(x,I).
- S_D: xd=mul(x,D).
- S_N: xnd=mul(sat(xd-dacc[ch]),N).
- S_UPD, integrator: icand = sat(iacc[ch]+xi), clamped to [-ILIM,+ILIM].
- S_UPD, anti-windup: iacc[ch] holds (no update) if sat_dir[ch]=+1 and xi>0, or sat_dir[ch]=-1 and xi<0. Otherwise iacc[ch]<=icand.
- S_UPD, derivative: dacc[ch] <= sat(dacc[ch]+xnd), clamped to [-DLIM,+DLIM].
- S_UPD, output: sum = xp + (new iacc) + xnd at W+2 bits. If sum>OLIM then y=OLIM, sat_dir=+1; if sum<-OLIM then y=-OLIM, sat_dir=-1; else y=sum, sat_dir=0.
- S_OUT: out_valid=1 with out_ch, out_data=y, out_sat=(sat_dir!=0). out_data/out_ch/out_sat hold their values until the next S_OUT.
- Latency: out_valid is high exactly 6 cycles after the accept edge.
- Throughput: one sample per 7 cycles; in_ready is high only in IDLE.
- Config writes: take effect the next cycle. cfg_ready=0 only while busy (not IDLE) and cfg_ch equals the in-flight channel. Writes to other channels proceed during processing.
- Snapshot rule: gains used by an in-flight sample are those at accept.
- Clear (sel 7): zeroes iacc, dacc and sat_dir of cfg_ch.
- Limits: are treated as magnitudes; a negative limit value behaves as 0. ILIM/DLIM/OLIM=0 forces that quantity to 0.
- Out-of-range index (in_ch>=CH or cfg_ch>=CH): the sample is accepted and dropped with no out_valid; the config write is ignored.
- rst mid-operation: aborts the in-flight sample, no out_valid, all state returns to reset values.

Test Plan:
- Proportional: ch0 P=0x20000 (2.0), others 0, OLIM=0x7FFFFFFF. in_data=0x18000 (1.5) -> out_valid 6 cycles after accept, out_data=0x30000, out_sat=0; in_ready low for 6 cycles.
- Integrator clamp: ch1 I*Ts=0x8000, ILIM=0x10000, OLIM large. Three samples 0x10000 -> outputs 0x8000, 0x10000, 0x10000.
- Anti-windup: ch2 I*Ts=0x10000, ILIM=0xA0000, OLIM=0x20000. Inputs 1.0 x4 then -1.0:
  - out 0x10000, 0x20000, 0x20000 (sat=1, iacc=0x30000), 0x20000 (iacc held at 0x30000);
  - then out 0x20000 with sat=0, iacc=0x20000.
- Derivative filter: ch3 D/Ts=0x10000, N*Ts=0x8000, DLIM large. Inputs 1.0, 1.0 -> outputs 0x8000 then 0x4000; dacc=0xC000.
- Floor rounding: P=0x8000, in_data=0xFFFFFFFF -> out_data=0xFFFFFFFF. Saturation: P=0x7FFFFFFF, in_data=0x7FFFFFFF -> out_data=0x7FFFFFFF (OLIM max), out_sat=0.
- Interleave, config and reset:
  - Alternate ch0/ch1 integrator samples -> independent accumulations.
  - cfg_we to the in-flight channel -> cfg_ready=0 and no change; cfg_we to another channel -> accepted.
  - rst asserted in S_D -> no out_valid, iacc=0 on the next sample.

Source files
------------

// File: rtl/pid_mc_if.sv
// Sample, configuration and result channels of the multi-channel PID controller.
// The bench drives the master side; the controller sits on the slave side.
interface pid_mc_if #(
    parameter int W  = 32,
    parameter int CH = 4
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic                in_valid;
    logic                in_ready;
    logic [CHW-1:0]      in_ch;
    logic signed [W-1:0] in_data;
    logic                cfg_we;
    logic                cfg_ready;
    logic [CHW-1:0]      cfg_ch;
    logic [2:0]          cfg_sel;
    logic signed [W-1:0] cfg_data;
    logic                out_valid;
    logic [CHW-1:0]      out_ch;
    logic signed [W-1:0] out_data;
    logic                out_sat;

    modport master (
        output in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data,
        input  in_ready, cfg_ready, out_valid, out_ch, out_data, out_sat
    );
    modport slave (
        input  in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data,
        output in_ready, cfg_ready, out_valid, out_ch, out_data, out_sat
    );
endinterface

// File: rtl/pid_mc.sv
// Time-multiplexed fixed-point PID for CH loops sharing one multiplier.
// One sample walks P, I, D, N, UPD, OUT in consecutive cycles.
module pid_mc #(
    parameter int W  = 32,
    parameter int FW = 16,
    parameter int CH = 4
) (
    input logic     clk,
    input logic     rst,
    pid_mc_if.slave bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int EW  = W + 2;
    localparam logic signed [W-1:0]   MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]   MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [EW-1:0]  EMAX = EW'(MAXV);
    localparam logic signed [EW-1:0]  EMIN = EW'(MINV);
    localparam logic signed [2*W-1:0] PMAX = (2*W)'(MAXV);
    localparam logic signed [2*W-1:0] PMIN = (2*W)'(MINV);
    localparam logic [CHW:0]          CHP  = (CHW+1)'(CH);

    typedef enum logic [2:0] {IDLE, S_P, S_I, S_D, S_N, S_UPD, S_OUT} state_t;
    typedef struct packed {
        logic signed [W-1:0] p, i, d, n, ilim, dlim, olim;
    } cfg_t;

    function automatic logic signed [EW-1:0] ext(input logic signed [W-1:0] v);
        return EW'(v);
    endfunction

    function automatic logic signed [W-1:0] satw(input logic signed [EW-1:0] v);
        if (v > EMAX)      return MAXV;
        else if (v < EMIN) return MINV;
        else               return v[W-1:0];
    endfunction

    // Full-width product, floor shift, then saturate back to W bits.
    function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] pr;
        pr = ((2*W)'(a) * (2*W)'(b)) >>> FW;
        if (pr > PMAX)      return MAXV;
        else if (pr < PMIN) return MINV;
        else                return pr[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] mag(input logic signed [W-1:0] l);
        return l[W-1] ? '0 : l;
    endfunction

    function automatic logic signed [W-1:0] clampm(input logic signed [W-1:0] v,
                                                   input logic signed [W-1:0] m);
        if (v > m)       return m;
        else if (v < -m) return -m;
        else             return v;
    endfunction

    state_t              state;
    cfg_t                cfg_r [CH];
    cfg_t                cs;
    logic signed [W-1:0] iacc [CH];
    logic signed [W-1:0] dacc [CH];
    logic signed [1:0]   sdir [CH];
    logic [CHW-1:0]      ch_r;
    logic signed [W-1:0] x_r, xp_r, xi_r, xd_r, xnd_r, y_r;
    logic                ysat_r;

    logic signed [W-1:0]  mop_a, mop_b, mres, dd, icand, inew, dnew, y;
    logic signed [EW-1:0] sum, om;
    logic signed [1:0]    ydir;
    logic                 hold, in_ok, cfg_ok;

    assign in_ok  = {1'b0, bus.in_ch} < CHP;
    assign cfg_ok = {1'b0, bus.cfg_ch} < CHP;
    assign bus.cfg_ready = (state == IDLE) || (bus.cfg_ch != ch_r);

    always_comb begin
        mop_a = x_r;
        mop_b = cs.p;
        case (state)
            S_I:     mop_b = cs.i;
            S_D:     mop_b = cs.d;
            S_N:     begin mop_a = dd; mop_b = cs.n; end
            default: ;
        endcase
    end

    assign mres  = mulq(mop_a, mop_b);
    assign dd    = satw(ext(xd_r) - ext(dacc[ch_r]));
    assign icand = clampm(satw(ext(iacc[ch_r]) + ext(xi_r)), mag(cs.ilim));
    // Integrator freezes while it would push further into the active output limit.
    assign hold  = (sdir[ch_r] == 2'sb01 && !xi_r[W-1] && xi_r != '0) ||
                   (sdir[ch_r] == 2'sb11 && xi_r[W-1]);
    assign inew  = hold ? iacc[ch_r] : icand;
    assign dnew  = clampm(satw(ext(dacc[ch_r]) + ext(xnd_r)), mag(cs.dlim));
    assign sum   = ext(xp_r) + ext(inew) + ext(xnd_r);
    assign om    = ext(mag(cs.olim));

    always_comb begin
        y    = sum[W-1:0];
        ydir = 2'sb00;
        if (sum > om) begin
            y    = om[W-1:0];
            ydir = 2'sb01;
        end else if (sum < -om) begin
            y    = -om[W-1:0];
            ydir = 2'sb11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            cs            <= '0;
            ch_r          <= '0;
            x_r           <= '0;
            xp_r          <= '0;
            xi_r          <= '0;
            xd_r          <= '0;
            xnd_r         <= '0;
            y_r           <= '0;
            ysat_r        <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                cfg_r[c] <= '0;
                iacc[c]  <= '0;
                dacc[c]  <= '0;
                sdir[c]  <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.cfg_we && bus.cfg_ready && cfg_ok) begin
                case (bus.cfg_sel)
                    3'd0: cfg_r[bus.cfg_ch].p    <= bus.cfg_data;
                    3'd1: cfg_r[bus.cfg_ch].i    <= bus.cfg_data;
                    3'd2: cfg_r[bus.cfg_ch].d    <= bus.cfg_data;
                    3'd3: cfg_r[bus.cfg_ch].n    <= bus.cfg_data;
                    3'd4: cfg_r[bus.cfg_ch].ilim <= bus.cfg_data;
                    3'd5: cfg_r[bus.cfg_ch].dlim <= bus.cfg_data;
                    3'd6: cfg_r[bus.cfg_ch].olim <= bus.cfg_data;
                    default: begin
                        iacc[bus.cfg_ch] <= '0;
                        dacc[bus.cfg_ch] <= '0;
                        sdir[bus.cfg_ch] <= '0;
                    end
                endcase
            end
            case (state)
                IDLE: if (bus.in_valid && in_ok) begin
                    ch_r         <= bus.in_ch;
                    x_r          <= bus.in_data;
                    cs           <= cfg_r[bus.in_ch];
                    bus.in_ready <= 1'b0;
                    state        <= S_P;
                end
                S_P: begin xp_r  <= mres; state <= S_I; end
                S_I: begin xi_r  <= mres; state <= S_D; end
                S_D: begin xd_r  <= mres; state <= S_N; end
                S_N: begin xnd_r <= mres; state <= S_UPD; end
                S_UPD: begin
                    iacc[ch_r] <= inew;
                    dacc[ch_r] <= dnew;
                    sdir[ch_r] <= ydir;
                    y_r        <= y;
                    ysat_r     <= (ydir != 2'sb00);
                    state      <= S_OUT;
                end
                S_OUT: begin
                    bus.out_valid <= 1'b1;
                    bus.out_ch    <= ch_r;
                    bus.out_data  <= y_r;
                    bus.out_sat   <= ysat_r;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
